// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: IF/ID, WB and EX-side signals of the decode stage bundled as one port.
interface id_stage_pipe_if #(parameter int DATA_W = 32, parameter int ADDR_W = 32);
  logic              ID_flush;
  logic              ID_stall_in;
  logic              IF_ID_valid;
  logic [31:0]       IF_ID_instruction;
  logic [ADDR_W-1:0] IF_ID_pc;
  logic              WB_ID_register_write;
  logic [4:0]        WB_ID_write_register;
  logic [DATA_W-1:0] WB_ID_write_data;
  logic [4:0]        EX_ID_rt;
  logic              EX_ID_memory_read;
  logic              pc_enable;
  logic              IF_enable;
  logic              ID_IF_jump;
  logic [ADDR_W-1:0] ID_IF_jump_target;
  logic              ID_IF_branch;
  logic              ID_EX_valid;
  logic [DATA_W-1:0] ID_EX_output_data_1;
  logic [DATA_W-1:0] ID_EX_output_data_2;
  logic [4:0]        ID_EX_rs;
  logic [4:0]        ID_EX_rt;
  logic [4:0]        ID_EX_rd;
  logic [DATA_W-1:0] ID_EX_immediate_extended;
  logic [ADDR_W-1:0] ID_EX_pc;
  logic              ID_EX_alusrc;
  logic [1:0]        ID_EX_alu_operation;
  logic              ID_EX_memory_read;
  logic              ID_EX_memory_write;
  logic              ID_EX_branch;
  logic              ID_EX_branch_ne;
  logic              ID_EX_memory_to_register;
  logic              ID_EX_register_write;
  logic              ID_EX_illegal;
  modport master (
    output ID_flush, ID_stall_in, IF_ID_valid, IF_ID_instruction, IF_ID_pc,
           WB_ID_register_write, WB_ID_write_register, WB_ID_write_data, EX_ID_rt, EX_ID_memory_read,
    input  pc_enable, IF_enable, ID_IF_jump, ID_IF_jump_target, ID_IF_branch,
           ID_EX_valid, ID_EX_output_data_1, ID_EX_output_data_2, ID_EX_rs, ID_EX_rt, ID_EX_rd,
           ID_EX_immediate_extended, ID_EX_pc, ID_EX_alusrc, ID_EX_alu_operation, ID_EX_memory_read,
           ID_EX_memory_write, ID_EX_branch, ID_EX_branch_ne, ID_EX_memory_to_register,
           ID_EX_register_write, ID_EX_illegal
  );
  modport slave (
    input  ID_flush, ID_stall_in, IF_ID_valid, IF_ID_instruction, IF_ID_pc,
           WB_ID_register_write, WB_ID_write_register, WB_ID_write_data, EX_ID_rt, EX_ID_memory_read,
    output pc_enable, IF_enable, ID_IF_jump, ID_IF_jump_target, ID_IF_branch,
           ID_EX_valid, ID_EX_output_data_1, ID_EX_output_data_2, ID_EX_rs, ID_EX_rt, ID_EX_rd,
           ID_EX_immediate_extended, ID_EX_pc, ID_EX_alusrc, ID_EX_alu_operation, ID_EX_memory_read,
           ID_EX_memory_write, ID_EX_branch, ID_EX_branch_ne, ID_EX_memory_to_register,
           ID_EX_register_write, ID_EX_illegal
  );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS-subset decode with register file, load-use hazard unit and ID/EX register.
module id_stage_pipe #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter bit BYPASS_EN    = 1,
  parameter bit R0_HARDWIRED = 1
) (
  input logic          clk,
  input logic          ID_rst_n,
  id_stage_pipe_if.slave id
);
  typedef struct packed {
    logic       alusrc;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       branch_ne;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;
  logic [31:0] instr;
  logic [5:0] op;
  logic [4:0] rs, rt, wa;
  logic is_r, is_lw, is_sw, is_addi, is_beq, is_bne, is_j;
  logic uses_rs, uses_rt, load_use, wr_ok;
  logic [DATA_W-1:0] rf [32];
  logic [DATA_W-1:0] rd1, rd2;
  ctrl_t ctrl_d, ctrl_q;
  assign instr   = id.IF_ID_instruction;
  assign op      = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign wa      = id.WB_ID_write_register;
  assign is_r    = op == 6'b000000;
  assign is_lw   = op == 6'b100011;
  assign is_sw   = op == 6'b101011;
  assign is_addi = op == 6'b001000;
  assign is_beq  = op == 6'b000100;
  assign is_bne  = op == 6'b000101;
  assign is_j    = op == 6'b000010;
  assign uses_rs = is_r | is_lw | is_sw | is_addi | is_beq | is_bne;
  assign uses_rt = is_r | is_sw | is_beq | is_bne;
  assign load_use = id.IF_ID_valid & id.EX_ID_memory_read & (id.EX_ID_rt != 5'd0) &
                    ((uses_rs & (id.EX_ID_rt == rs)) | (uses_rt & (id.EX_ID_rt == rt)));
  assign wr_ok = id.WB_ID_register_write & ~(R0_HARDWIRED & (wa == 5'd0));
  // wr_ok already excludes r0 when hardwired, so the bypass never leaks a value into r0
  assign rd1 = (R0_HARDWIRED && rs == 5'd0) ? '0 : (BYPASS_EN && wr_ok && wa == rs) ? id.WB_ID_write_data : rf[rs];
  assign rd2 = (R0_HARDWIRED && rt == 5'd0) ? '0 : (BYPASS_EN && wr_ok && wa == rt) ? id.WB_ID_write_data : rf[rt];
  assign ctrl_d = id.IF_ID_valid ? ctrl_t'{
    alusrc:     is_lw | is_sw | is_addi,
    alu_op:     is_r ? 2'b10 : (is_beq | is_bne) ? 2'b01 : 2'b00,
    mem_read:   is_lw,
    mem_write:  is_sw,
    branch:     is_beq | is_bne,
    branch_ne:  is_bne,
    mem_to_reg: is_lw,
    reg_write:  is_r | is_lw | is_addi,
    illegal:    ~(uses_rs | is_j)
  } : ctrl_t'('0);
  assign id.pc_enable         = ~(load_use | id.ID_stall_in);
  assign id.IF_enable         = ~(load_use | id.ID_stall_in);
  assign id.ID_IF_jump        = id.IF_ID_valid & is_j & ~id.ID_flush & ~load_use;
  assign id.ID_IF_jump_target = {id.IF_ID_pc[ADDR_W-1:28], instr[25:0], 2'b00};
  assign id.ID_IF_branch      = id.IF_ID_valid & (is_beq | is_bne);
  always_ff @(posedge clk)
    if (!ID_rst_n) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (wr_ok) rf[wa] <= id.WB_ID_write_data;
  always_ff @(posedge clk)
    if (!ID_rst_n || id.ID_flush) begin
      id.ID_EX_valid              <= 1'b0;
      ctrl_q                      <= '0;
      id.ID_EX_output_data_1      <= '0;
      id.ID_EX_output_data_2      <= '0;
      id.ID_EX_rs                 <= '0;
      id.ID_EX_rt                 <= '0;
      id.ID_EX_rd                 <= '0;
      id.ID_EX_immediate_extended <= '0;
      id.ID_EX_pc                 <= '0;
    end else if (!id.ID_stall_in) begin
      id.ID_EX_valid <= id.IF_ID_valid & ~load_use;
      ctrl_q         <= load_use ? '0 : ctrl_d;
      if (!load_use) begin
        id.ID_EX_output_data_1      <= rd1;
        id.ID_EX_output_data_2      <= rd2;
        id.ID_EX_rs                 <= rs;
        id.ID_EX_rt                 <= rt;
        id.ID_EX_rd                 <= instr[15:11];
        id.ID_EX_immediate_extended <= DATA_W'($signed(instr[15:0]));
        id.ID_EX_pc                 <= id.IF_ID_pc;
      end
    end
  assign {id.ID_EX_alusrc, id.ID_EX_alu_operation, id.ID_EX_memory_read, id.ID_EX_memory_write,
          id.ID_EX_branch, id.ID_EX_branch_ne, id.ID_EX_memory_to_register,
          id.ID_EX_register_write, id.ID_EX_illegal} = ctrl_q;
endmodule
